flag_register_unit: RTL and testbench
=====================================

Name: flag_register_unit

Overview:
- Writer side of the processor's 4-bit flag bus, `{rsvd, Z, V, N}` with Z in bit 2, V in bit 1 and N in bit 0.
- Computes N/Z/V from the EX-stage ALU result and commits them to the architectural flag register under per-opcode write masks.
- Drives a branch-resolution flag view to the ID-stage next-PC logic. That view is either bypassed from EX or held off by a one-cycle hazard stall.
- Sits between the ALU (EX) and branch condition evaluation (ID).

Parameters:
- BYPASS, 1, 1 = forward EX-computed flags to `flags_br`; 0 = stall ID on a flag hazard instead.
- CNT_W, 16, width of the saturating hazard/stall event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_opcode  input  4  EX instruction opcode.
- ex_result  input  16  ALU result of the EX instruction.
- ex_ovfl  input  1  ALU signed-overflow indication for ADD/SUB.
- stall_in  input  1  pipeline freeze; no commit while high.
- flush_ex  input  1  squash the EX instruction; no commit.
- id_branch  input  1  ID holds a conditional branch (B/BR) that reads flags this cycle.
- flags  output  4  architectural flag register `{1'b0, Z, V, N}`.
- flags_br  output  4  flags presented to branch resolution.
- flag_stall  output  1  request to hold IF/ID and bubble EX.
- hazard_cnt  output  CNT_W  saturating count of flag-hazard events.

Behaviour:
- Reset (async, rst_n low): flags=4'b0000, state=IDLE, hazard_cnt=0. flag_stall and flags_br then follow their combinational rules from reset state: flag_stall=0, flags_br=0 unless a hazard is present.
- flags[3] is always 0.
- Write masks:
  - ADD (4'h0) and SUB (4'h1): write Z, V and N.
  - XOR (4'h2), SLL (4'h4), SRA (4'h5), ROR (4'h6): write Z only.
  - All other opcodes: write nothing.
- Next-flag values: Z = (ex_result == 16'h0000); N = ex_result[15]; V = ex_ovfl. Bits outside the mask keep their old value.
- Commit condition: ex_valid & ~flush_ex & ~stall_in & (mask != 0). Flags update on that rising edge, so `flags` has 1-cycle latency.
- flush_ex and stall_in together: no commit. flush_ex has priority.
- Hazard definition: hazard = id_branch & ex_valid & ~flush_ex & (mask != 0).
- BYPASS=1:
  - flags_br = masked merge of the EX next-flags over the registered `flags`, combinational, same cycle.
  - flag_stall is held at 0.
  - hazard_cnt increments once per cycle in which hazard & ~stall_in.
- BYPASS=0 stall FSM (flags_br = flags at all times):
  - IDLE: flag_stall = hazard. If hazard: increment hazard_cnt; go to WAIT when ~stall_in, otherwise stay in IDLE.
  - WAIT: flag_stall = 0; the committed flags are now visible. Return to IDLE next cycle.
  - A new hazard arising in WAIT is handled on return to IDLE. The FSM never issues back-to-back stalls for the same instruction.
- hazard_cnt saturates at all-ones with no wrap.
- Reset asserted mid-stall: state returns to IDLE and flag_stall drops immediately (asynchronous).
- Simultaneous commit and read with BYPASS=1: branch sees the new value. With BYPASS=0: branch sees the old value only in a cycle where flag_stall=1, and that cycle is discarded by the stall.

Decomposition:
- Shared package `wisc_pkg`:
  - opcode localparams (OP_ADD … OP_ROR);
  - flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - state enum `{IDLE, WAIT}`;
  - 3-bit mask typedef.
- One combinational sub-module `flag_calc`: takes opcode, result and ovfl; produces next_flags[2:0] and mask[2:0]. The stall FSM, flag register and counter stay in the top module.

Test Plan:
- Reset, then ADD with result 16'h0000 and ovfl=1, valid, no stall → flags=4'b0110 one cycle later; hazard_cnt=0.
- With flags=4'b0111, XOR result 16'h8001 → flags=4'b0011: Z cleared, V and N unchanged despite result[15]=1.
- BYPASS=1: SUB result 16'hFFFE in EX together with id_branch=1 → flags_br=4'b0001 in the same cycle, flag_stall=0, hazard_cnt +1.
- BYPASS=0: same as above → flag_stall=1 for exactly one cycle, FSM goes IDLE→WAIT→IDLE, flags_br=4'b0001 in the WAIT cycle.
- ADD with flush_ex=1, or with stall_in=1 → flags unchanged. With stall_in=1 held for 3 cycles under BYPASS=0, flag_stall stays 1 for those 3 cycles, but hazard_cnt increments on every stalled cycle (it counts hazard-present cycles, not distinct events).
- Force hazard_cnt to all-ones, then trigger a hazard → count stays at all-ones. Pulse rst_n low in the WAIT state → flag_stall=0, flags=0 immediately.

Source files
------------

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared opcodes, flag indices, stall FSM states and write-mask type
package wisc_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef logic [2:0] mask_t;

  // Which of {Z, V, N} an opcode is allowed to write
  function automatic mask_t op_mask(input logic [3:0] op);
    mask_t m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_calc.sv
// rtl/flag_calc.sv - next N/Z/V values and write mask for the EX instruction
module flag_calc
  import wisc_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [15:0] result,
  input  logic        ovfl,
  output logic [2:0]  next_flags,
  output mask_t       mask
);

  // Candidate flags from the ALU result; the mask decides which ones land
  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_Z] = (result == 16'h0000);
    next_flags[FLAG_V] = ovfl;
    next_flags[FLAG_N] = result[15];
    mask               = op_mask(opcode);
  end

endmodule

// File: rtl/flag_register_unit.sv
// rtl/flag_register_unit.sv - architectural flag register with branch bypass or hazard stall
module flag_register_unit
  import wisc_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      ex_result,
  input  logic             ex_ovfl,
  input  logic             stall_in,
  input  logic             flush_ex,
  input  logic             id_branch,
  output logic [3:0]       flags,
  output logic [3:0]       flags_br,
  output logic             flag_stall,
  output logic [CNT_W-1:0] hazard_cnt
);

  logic [2:0] next_flags;
  mask_t      mask;
  logic [2:0] flag_q;
  logic [2:0] merged;
  state_t     state;
  logic       live;
  logic       commit;
  logic       hazard;
  logic       count_en;

  flag_calc u_calc (
    .opcode     (ex_opcode),
    .result     (ex_result),
    .ovfl       (ex_ovfl),
    .next_flags (next_flags),
    .mask       (mask)
  );

  // A live writer is a real, unsquashed EX instruction that touches some flag
  assign live     = ex_valid & ~flush_ex & (mask != 3'b000);
  assign commit   = live & ~stall_in;
  assign hazard   = id_branch & live;
  assign merged   = (flag_q & ~mask) | (next_flags & mask);

  assign flags      = {1'b0, flag_q};
  assign flags_br   = (BYPASS && hazard) ? {1'b0, merged} : flags;
  assign flag_stall = !BYPASS && (state == IDLE) && hazard;
  // Stall mode counts every hazard cycle seen in IDLE, including frozen ones
  assign count_en   = BYPASS ? (hazard & ~stall_in) : ((state == IDLE) && hazard);

  // Flag register: masked commit of the EX flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      flag_q <= '0;
    else if (commit) flag_q <= merged;
  end

  // Stall FSM: one stall cycle, then one cycle where the committed flags are read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!BYPASS && hazard && !stall_in) state <= WAIT;
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating hazard event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hazard_cnt <= '0;
    else if (count_en && (hazard_cnt != {CNT_W{1'b1}}))
      hazard_cnt <= hazard_cnt + 1'b1;
  end

endmodule

// File: tb/tb_flag_register_unit.sv
// tb/tb_flag_register_unit.sv - directed self-checking bench for both bypass and stall builds
module tb_flag_register_unit;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = 4'h0;
  logic [15:0] ex_result = 16'h0;
  logic        ex_ovfl = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_ex = 1'b0;
  logic        id_branch = 1'b0;

  logic [3:0]  flags1, br1, flags0, br0;
  logic        st1, st0;
  logic [15:0] cnt1;
  logic [2:0]  cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flag_register_unit #(.BYPASS(1'b1), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall_in(stall_in),
    .flush_ex(flush_ex), .id_branch(id_branch), .flags(flags1),
    .flags_br(br1), .flag_stall(st1), .hazard_cnt(cnt1)
  );

  flag_register_unit #(.BYPASS(1'b0), .CNT_W(3)) d0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall_in(stall_in),
    .flush_ex(flush_ex), .id_branch(id_branch), .flags(flags0),
    .flags_br(br0), .flag_stall(st0), .hazard_cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic stl, input logic fl, input logic br);
    ex_valid  = v;
    ex_opcode = op;
    ex_result = res;
    ex_ovfl   = ov;
    stall_in  = stl;
    flush_ex  = fl;
    id_branch = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_flags1", 16'(flags1), 16'h0);
    chk("rst_cnt1", cnt1, 16'h0);
    chk("rst_br1", 16'(br1), 16'h0);
    chk("rst_stall0", 16'(st0), 16'h0);
    chk("rst_cnt0", 16'(cnt0), 16'h0);
    rst_n = 1'b1;

    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("add_latency", 16'(flags1), 16'h0);
    tick();
    chk("add_flags1", 16'(flags1), 16'h6);
    chk("add_flags0", 16'(flags0), 16'h6);
    chk("add_cnt1", cnt1, 16'h0);

    drive(1'b1, OP_SUB, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub_flags1", 16'(flags1), 16'h3);
    drive(1'b1, OP_XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("xor_z_set", 16'(flags1), 16'h7);
    drive(1'b1, OP_XOR, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("xor_z_only1", 16'(flags1), 16'h3);
    chk("xor_z_only0", 16'(flags0), 16'h3);

    drive(1'b1, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("nomask_br1", 16'(br1), 16'h3);
    chk("nomask_stall0", 16'(st0), 16'h0);
    tick();
    chk("nomask_flags1", 16'(flags1), 16'h3);
    chk("nomask_cnt1", cnt1, 16'h0);
    chk("nomask_cnt0", 16'(cnt0), 16'h0);

    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("flush_br1", 16'(br1), 16'h3);
    chk("flush_stall0", 16'(st0), 16'h0);
    tick();
    chk("flush_flags1", 16'(flags1), 16'h3);
    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stallin_flags1", 16'(flags1), 16'h3);
    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("stall_flush_flags0", 16'(flags0), 16'h3);

    drive(1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("haz_br1", 16'(br1), 16'h1);
    chk("haz_stall1", 16'(st1), 16'h0);
    chk("haz_stall0", 16'(st0), 16'h1);
    chk("haz_br0_old", 16'(br0), 16'h3);
    tick();
    chk("haz_flags1", 16'(flags1), 16'h1);
    chk("haz_cnt1", cnt1, 16'h1);
    chk("haz_cnt0", 16'(cnt0), 16'h1);
    chk("haz_state_wait", 16'(d0.state), 16'h1);
    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("wait_stall0", 16'(st0), 16'h0);
    chk("wait_br0", 16'(br0), 16'h1);
    tick();
    chk("wait_state_idle", 16'(d0.state), 16'h0);
    chk("wait_cnt1", cnt1, 16'h1);

    drive(1'b1, OP_ADD, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_stall0", 16'(st0), 16'h1);
      chk("frz_br1", 16'(br1), 16'h0);
      tick();
    end
    chk("frz_flags1", 16'(flags1), 16'h1);
    chk("frz_cnt0", 16'(cnt0), 16'h4);
    chk("frz_cnt1", cnt1, 16'h1);
    chk("frz_state", 16'(d0.state), 16'h0);
    drive(1'b1, OP_ADD, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("rel_stall0", 16'(st0), 16'h1);
    tick();
    chk("rel_flags0", 16'(flags0), 16'h0);
    chk("rel_cnt0", 16'(cnt0), 16'h5);
    chk("rel_cnt1", cnt1, 16'h2);
    chk("rel_state", 16'(d0.state), 16'h1);

    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, OP_ADD, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    chk("sat_cnt0", 16'(cnt0), 16'h7);
    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("sat_stall0", 16'(st0), 16'h1);
    tick();
    chk("sat_hold_cnt0", 16'(cnt0), 16'h7);
    chk("sat_cnt1", cnt1, 16'h3);
    chk("sat_flags0", 16'(flags0), 16'h6);
    chk("sat_state", 16'(d0.state), 16'h1);

    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("arst_stall0", 16'(st0), 16'h0);
    chk("arst_flags0", 16'(flags0), 16'h0);
    chk("arst_state", 16'(d0.state), 16'h0);
    chk("arst_cnt0", 16'(cnt0), 16'h0);
    chk("arst_flags1", 16'(flags1), 16'h0);
    chk("arst_cnt1", cnt1, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
